// File: rtl/aes_pkg.sv
// AES-128 shared tables, GF(2^8) helpers and FSM state type for the round cores.
package aes_pkg;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

  // Forward S-box; entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, same layout.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? ({1'b0, x[7:1]} ^ 8'h8d) : {1'b0, x[7:1]};
  endfunction

  // GF(2^8) multiply by a 4-bit constant (used with 9, 11, 13, 14).
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] m);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Byte 0 of a word lives in the low bits, so RotWord moves the low byte to the top.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[7:0];
    a1 = w[15:8];
    a2 = w[23:16];
    a3 = w[31:24];
    return {gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14),
            gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
            gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
            gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mixw(s[127:96]), inv_mixw(s[95:64]), inv_mixw(s[63:32]), inv_mixw(s[31:0])};
  endfunction

  // Row r of column c comes from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[32*c + 8*r +: 8] = s[32*((c + 4 - r) % 4) + 8*r +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_dec_inv_ks.sv
// Inverse AES-128 key-schedule step: round key r+1 -> round key r, with the rcon stepped back.
module aes_inv_ks
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_prev_o,
  output logic [7:0]   rcon_prev_o
);

  logic [31:0] p0, p1, p2, p3;

  // Undo the xor chain first; w3 of the earlier key feeds the SubWord term.
  always_comb begin
    p3          = key_i[127:96] ^ key_i[95:64];
    p2          = key_i[95:64] ^ key_i[63:32];
    p1          = key_i[63:32] ^ key_i[31:0];
    p0          = key_i[31:0] ^ sub_word(rot_word(p3)) ^ {24'h0, rcon_i};
    key_prev_o  = {p3, p2, p1, p0};
    rcon_prev_o = inv_xtime(rcon_i);
  end

endmodule

// File: rtl/aes_ks.sv
// Forward AES-128 key-schedule step: round key r -> round key r+1.
module aes_ks
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] t, n0, n1, n2, n3;

  // rcon lands on the first byte of the word, which is the low byte here.
  always_comb begin
    t     = sub_word(rot_word(key_i[127:96])) ^ {24'h0, rcon_i};
    n0    = key_i[31:0] ^ t;
    n1    = key_i[63:32] ^ n0;
    n2    = key_i[95:64] ^ n1;
    n3    = key_i[127:96] ^ n2;
    key_o = {n3, n2, n1, n0};
  end

endmodule

// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher: forward key expansion, then 10 inverse rounds.
module aes_dec
  import aes_pkg::*;
#(
  parameter bit KEY_REUSE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_v_i,
  input  logic [127:0] data_i,
  input  logic [127:0] key_i,
  input  logic         key_reuse_i,
  output logic         ready_o,
  output logic         res_v_o,
  output logic [127:0] res_o
);

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] data_q, key_q, cache_q, res_q;
  logic [7:0]   rcon_q;
  logic         cache_v;

  logic [127:0] key_next, key_prev, dec_t;
  logic [7:0]   rcon_prev;
  logic         accept, use_cache;

  aes_ks u_ks (
    .key_i  (key_q),
    .rcon_i (rcon_q),
    .key_o  (key_next)
  );

  aes_inv_ks u_inv_ks (
    .key_i       (key_q),
    .rcon_i      (rcon_q),
    .key_prev_o  (key_prev),
    .rcon_prev_o (rcon_prev)
  );

  assign dec_t     = inv_sub_bytes(inv_shift_rows(data_q)) ^ key_prev;
  assign ready_o   = (state == IDLE) || (state == DONE);
  assign res_v_o   = (state == DONE);
  assign res_o     = res_q;
  assign accept    = data_v_i && ready_o;
  assign use_cache = KEY_REUSE && key_reuse_i && cache_v;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      data_q  <= '0;
      key_q   <= '0;
      rcon_q  <= 8'h00;
      cache_q <= '0;
      cache_v <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (use_cache) begin
              data_q <= data_i ^ cache_q;
              key_q  <= cache_q;
              rcon_q <= RCON_LAST;
              cnt    <= 4'd9;
              state  <= DEC;
            end else begin
              data_q <= data_i;
              key_q  <= key_i;
              rcon_q <= RCON_FIRST;
              cnt    <= 4'd0;
              state  <= KEXP;
            end
          end else begin
            state <= IDLE;
          end
        end
        KEXP: begin
          key_q <= key_next;
          if (cnt == 4'd9) begin
            data_q  <= data_q ^ key_next;
            cache_q <= key_next;
            cache_v <= KEY_REUSE;
            rcon_q  <= RCON_LAST;
            cnt     <= 4'd9;
            state   <= DEC;
          end else begin
            rcon_q <= xtime(rcon_q);
            cnt    <= cnt + 4'd1;
          end
        end
        DEC: begin
          key_q  <= key_prev;
          rcon_q <= rcon_prev;
          if (cnt == 4'd0) begin
            data_q <= dec_t;
            res_q  <= dec_t;
            state  <= DONE;
          end else begin
            data_q <= inv_mix_columns(dec_t);
            cnt    <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec.sv
// Directed testbench for aes_dec using FIPS-197 vectors.
module tb_aes_dec;
  import aes_pkg::*;

  // Vectors written in FIPS byte order (byte 0 leftmost).
  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] JUNK    = 128'hdeadbeef0badf00dcafebabe12345678;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         v1 = 1'b0, v0 = 1'b0;
  logic [127:0] data = '0, key = '0;
  logic         reuse = 1'b0;
  logic         rdy1, rv1, rdy0, rv0;
  logic [127:0] res1, res0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_dec #(.KEY_REUSE(1'b1)) d1 (
    .clk(clk), .reset(reset), .data_v_i(v1), .data_i(data), .key_i(key),
    .key_reuse_i(reuse), .ready_o(rdy1), .res_v_o(rv1), .res_o(res1)
  );

  aes_dec #(.KEY_REUSE(1'b0)) d0 (
    .clk(clk), .reset(reset), .data_v_i(v0), .data_i(data), .key_i(key),
    .key_reuse_i(reuse), .ready_o(rdy0), .res_v_o(rv0), .res_o(res0)
  );

  function automatic logic [127:0] fips(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = x[8*(15-k) +: 8];
    return y;
  endfunction

  // Present one request for a single edge; called 1 time unit after an edge.
  task automatic accept(input bit sel, input bit ru, input logic [127:0] ct, input logic [127:0] k);
    data  = fips(ct);
    key   = fips(k);
    reuse = ru;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v0 = 1'b0; reuse = 1'b0;
  endtask

  // Wait for the result pulse; lat counts edges after the acceptance edge (-1 on timeout).
  task automatic wait_res(input bit sel, input int max, output int lat,
                          output logic [127:0] pt, output int lowcnt);
    lat = -1; pt = '0; lowcnt = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (sel ? rv1 : rv0) begin
        lat = i;
        pt  = sel ? res1 : res0;
        break;
      end
      if (!(sel ? rdy1 : rdy0)) lowcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy1); end
    n_tests++; if (rv1 !== 1'b0) begin n_fail++; $display("FAIL reset_res_v: got %b want 0", rv1); end
    n_tests++; if (res1 !== 128'h0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res1); end
    n_tests++; if (d1.cache_v !== 1'b0) begin n_fail++; $display("FAIL reset_cache_v: got %b want 0", d1.cache_v); end
    n_tests++; if (d1.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", d1.state); end
    n_tests++; if (rdy0 !== 1'b1 || rv0 !== 1'b0) begin n_fail++; $display("FAIL reset_d0: got ready %b res_v %b want 1 0", rdy0, rv0); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reuse_no_key();
    int lat, low; logic [127:0] pt;
    accept(1'b1, 1'b1, C1_CT, C1_KEY);
    wait_res(1'b1, 40, lat, pt, low);
    n_tests++; if (lat != 20) begin n_fail++; $display("FAIL nokey_latency: got %0d want 20", lat); end
    n_tests++; if (pt !== fips(C1_PT)) begin n_fail++; $display("FAIL nokey_pt: got %h want %h", pt, fips(C1_PT)); end
  endtask

  task automatic test_c1();
    int lat, low; logic [127:0] pt;
    accept(1'b1, 1'b0, C1_CT, C1_KEY);
    wait_res(1'b1, 40, lat, pt, low);
    n_tests++; if (lat != 20) begin n_fail++; $display("FAIL c1_latency: got %0d want 20", lat); end
    n_tests++; if (pt !== fips(C1_PT)) begin n_fail++; $display("FAIL c1_pt: got %h want %h", pt, fips(C1_PT)); end
    n_tests++; if (low != 19) begin n_fail++; $display("FAIL c1_ready_low: got %0d cycles want 19", low); end
    @(posedge clk); #1;
    n_tests++; if (rv1 !== 1'b0 || res1 !== fips(C1_PT)) begin n_fail++; $display("FAIL c1_after: got res_v %b res %h want 0 and held pt", rv1, res1); end
  endtask

  task automatic test_appb();
    int lat, low; logic [127:0] pt;
    accept(1'b1, 1'b0, B_CT, B_KEY);
    repeat (10) @(posedge clk);
    #1;
    n_tests++; if (d1.state !== DEC) begin n_fail++; $display("FAIL appb_state10: got %0d want DEC", d1.state); end
    n_tests++; if (d1.key_q !== fips(B_RK10)) begin n_fail++; $display("FAIL appb_rk10: got %h want %h", d1.key_q, fips(B_RK10)); end
    wait_res(1'b1, 30, lat, pt, low);
    n_tests++; if (lat != 10) begin n_fail++; $display("FAIL appb_dec_latency: got %0d want 10", lat); end
    n_tests++; if (pt !== fips(B_PT)) begin n_fail++; $display("FAIL appb_pt: got %h want %h", pt, fips(B_PT)); end
  endtask

  task automatic test_back_to_back();
    int lat, low; logic [127:0] pt;
    accept(1'b1, 1'b0, B_CT, B_KEY);
    wait_res(1'b1, 40, lat, pt, low);
    n_tests++; if (lat != 20 || pt !== fips(B_PT)) begin n_fail++; $display("FAIL b2b_first: got lat %0d pt %h want 20 %h", lat, pt, fips(B_PT)); end
    // Accept in the DONE cycle; a junk key_i proves the cached key is used.
    accept(1'b1, 1'b1, B_CT, JUNK);
    wait_res(1'b1, 40, lat, pt, low);
    n_tests++; if (lat != 10) begin n_fail++; $display("FAIL b2b_reuse_latency: got %0d want 10", lat); end
    n_tests++; if (pt !== fips(B_PT)) begin n_fail++; $display("FAIL b2b_reuse_pt: got %h want %h", pt, fips(B_PT)); end
    // Without the cache the reuse flag is ignored.
    accept(1'b0, 1'b0, B_CT, B_KEY);
    wait_res(1'b0, 40, lat, pt, low);
    n_tests++; if (lat != 20 || pt !== fips(B_PT)) begin n_fail++; $display("FAIL b2b_nocache_first: got lat %0d pt %h want 20 %h", lat, pt, fips(B_PT)); end
    accept(1'b0, 1'b1, B_CT, B_KEY);
    wait_res(1'b0, 40, lat, pt, low);
    n_tests++; if (lat != 20) begin n_fail++; $display("FAIL b2b_nocache_latency: got %0d want 20", lat); end
    n_tests++; if (pt !== fips(B_PT)) begin n_fail++; $display("FAIL b2b_nocache_pt: got %h want %h", pt, fips(B_PT)); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat, pulses; logic [127:0] pt;
    lat = -1; pulses = 0; pt = '0;
    accept(1'b1, 1'b0, B_CT, B_KEY);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (rv1) begin
        pulses++;
        if (lat < 0) begin lat = i; pt = res1; end
      end
      if (i == 3 || i == 13) begin
        data = fips(C1_CT); key = fips(C1_KEY); v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
    end
    v1 = 1'b0;
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    n_tests++; if (lat != 20) begin n_fail++; $display("FAIL busy_latency: got %0d want 20", lat); end
    n_tests++; if (pt !== fips(B_PT)) begin n_fail++; $display("FAIL busy_pt: got %h want %h", pt, fips(B_PT)); end
  endtask

  task automatic test_reset_mid();
    int lat, low; logic [127:0] pt;
    accept(1'b1, 1'b0, B_CT, B_KEY);
    repeat (14) @(posedge clk);
    #1;
    n_tests++; if (d1.state !== DEC || d1.cnt !== 4'd5) begin n_fail++; $display("FAIL mid_round: got state %0d cnt %0d want DEC 5", d1.state, d1.cnt); end
    reset = 1'b1;
    #1;
    n_tests++; if (rv1 !== 1'b0) begin n_fail++; $display("FAIL mid_res_v: got %b want 0", rv1); end
    n_tests++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", rdy1); end
    n_tests++; if (res1 !== 128'h0) begin n_fail++; $display("FAIL mid_res: got %h want 0", res1); end
    n_tests++; if (d1.cache_v !== 1'b0) begin n_fail++; $display("FAIL mid_cache_v: got %b want 0", d1.cache_v); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    // Reuse request with an invalidated cache must fall back to key_i.
    accept(1'b1, 1'b1, C1_CT, C1_KEY);
    wait_res(1'b1, 40, lat, pt, low);
    n_tests++; if (lat != 20) begin n_fail++; $display("FAIL mid_fallback_latency: got %0d want 20", lat); end
    n_tests++; if (pt !== fips(C1_PT)) begin n_fail++; $display("FAIL mid_fallback_pt: got %h want %h", pt, fips(C1_PT)); end
  endtask

  initial begin
    test_reset();
    test_reuse_no_key();
    test_c1();
    test_appb();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
